// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module  : sevenseg_pkg
// Brief   : Shared types, glyph table and FSM encoding for the 7-seg mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF_AL = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam seg_t HEX_GLYPH_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
// Module  : seg_hex_decode
// Brief   : Combinational hex nibble to active-low gfedcba glyph.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg_al
);

  assign o_seg_al = HEX_GLYPH_AL[i_nibble];

endmodule

`default_nettype wire

// File: rtl/sevenseg_mux.sv
// ============================================================================
// Module  : sevenseg_mux
// Brief   : Time-multiplexed common-anode 7-segment driver with blanking gap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 64,
  parameter int INVERT_IN      = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(max_int(REFRESH_CYCLES, BLANK_CYCLES) + 1);
  localparam int IDX_W = max_int($clog2(NUM_DIGITS), 1);

  localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(max_int(BLANK_CYCLES, 1) - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam seg_t                  C_SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic                  C_DP_XOR  = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] C_AN_XOR  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("sevenseg_mux: NUM_DIGITS must be >= 1");
  end
  if (REFRESH_CYCLES < 1) begin : g_bad_refresh
    $error("sevenseg_mux: REFRESH_CYCLES must be >= 1");
  end

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_mask;
  seg_t                    r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                    w_last;
  logic                    w_frame_edge;
  logic                    w_lit;
  logic [3:0]              w_nibble_raw;
  logic [3:0]              w_nibble;
  seg_t                    w_glyph_al;
  seg_t                    w_seg_al;
  logic                    w_dp_al;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  assign w_last       = (r_state == S_ON) ? (r_cnt == C_ON_LAST) : (r_cnt == C_BLANK_LAST);
  assign w_frame_edge = (r_state == S_BLANK) && (r_cnt == '0) && (r_idx == '0);

  assign w_nibble_raw = r_snap_digits[{r_idx, 2'b00} +: 4];
  assign w_nibble     = (INVERT_IN != 0) ? ~w_nibble_raw : w_nibble_raw;

  seg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg_al (w_glyph_al)
  );

  // Everything is resolved in active-low segment / active-high anode terms,
  // then the pin polarity is applied once at the output registers.
  always_comb begin
    w_an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_onehot[i] = (r_idx == IDX_W'(i));
    end
  end

  assign w_lit    = (r_state == S_ON) && !r_snap_mask[r_idx];
  assign w_seg_al = w_lit ? w_glyph_al : SEG_OFF_AL;
  assign w_dp_al  = w_lit ? ~r_snap_dp[r_idx] : 1'b1;
  assign w_an_hi  = w_lit ? w_an_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_mask   <= '0;
      r_seg         <= SEG_OFF_AL ^ C_SEG_XOR;
      r_dp          <= 1'b1 ^ C_DP_XOR;
      r_an          <= C_AN_XOR;
      r_frame_start <= 1'b0;
    end else begin
      if (w_last) begin
        r_cnt <= '0;
        if (r_state == S_ON) begin
          r_state <= S_BLANK;
          r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_state <= S_ON;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_frame_edge) begin
        r_snap_digits <= digits;
        r_snap_dp     <= dp_in;
        r_snap_mask   <= blank_mask;
      end

      r_frame_start <= w_frame_edge;
      r_seg         <= w_seg_al ^ C_SEG_XOR;
      r_dp          <= w_dp_al ^ C_DP_XOR;
      r_an          <= w_an_hi ^ C_AN_XOR;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire
